// File: rtl/frontend_pkg.sv
// Shared types and constants for the frontend maintenance / redirect logic.
package frontend_pkg;

  localparam int PC_W   = 32;
  localparam int PRIV_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } flush_state_t;

endpackage

// File: rtl/inflight_counter.sv
// Saturating up/down counter of in-flight requests; never underflows below zero.
module inflight_counter #(
  parameter int MAX = 2,
  parameter int W   = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != MaxVal)) begin
      count_d = count_q + W'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/frontend_flush_ctrl.sv
// Sequences FENCE.I / SFENCE I-cache maintenance around the frontend and
// arbitrates the frontend redirect port between execute and the restart redirect.
module frontend_flush_ctrl
  import frontend_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int OUTSTANDING_W   = 2,
  parameter int FLUSH_TIMEOUT   = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              exec_branch_request_i,
  input  logic [PC_W-1:0]   exec_branch_pc_i,
  input  logic [PRIV_W-1:0] exec_branch_priv_i,
  input  logic              maint_req_i,
  input  logic              maint_invalidate_i,
  input  logic [PC_W-1:0]   maint_pc_i,
  input  logic [PRIV_W-1:0] maint_priv_i,
  input  logic              icache_rd_i,
  input  logic              icache_accept_i,
  input  logic              icache_valid_i,
  output logic              branch_request_o,
  output logic [PC_W-1:0]   branch_pc_o,
  output logic [PRIV_W-1:0] branch_priv_o,
  output logic              fetch_invalidate_o,
  output logic              icache_flush_o,
  output logic              icache_invalidate_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o
);

  localparam int TMO_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(FLUSH_TIMEOUT - 1);

  flush_state_t      state_q, state_d;
  logic              op_q, op_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PRIV_W-1:0] priv_q, priv_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              timeout_q, timeout_d;

  logic [OUTSTANDING_W-1:0] outstanding;
  logic                     outstanding_zero;

  inflight_counter #(
    .MAX (MAX_OUTSTANDING),
    .W   (OUTSTANDING_W)
  ) u_inflight (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (icache_rd_i & icache_accept_i),
    .dec_i   (icache_valid_i),
    .count_o (outstanding),
    .zero_o  (outstanding_zero)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      pc_q      <= '0;
      priv_q    <= '0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pc_q      <= pc_d;
      priv_q    <= priv_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pc_d      = pc_q;
    priv_d    = priv_q;
    tmo_d     = tmo_q;
    timeout_d = timeout_q;

    fetch_invalidate_o  = 1'b0;
    icache_flush_o      = 1'b0;
    icache_invalidate_o = 1'b0;
    done_o              = 1'b0;
    branch_request_o    = exec_branch_request_i;
    branch_pc_o         = exec_branch_pc_i;
    branch_priv_o       = exec_branch_priv_i;

    unique case (state_q)
      IDLE: begin
        if (maint_req_i) begin
          state_d = DRAIN;
          op_d    = maint_invalidate_i;
          pc_d    = maint_pc_i;
          priv_d  = maint_priv_i;
        end
      end
      DRAIN: begin
        fetch_invalidate_o = 1'b1;
        if (outstanding_zero) begin
          state_d = FLUSH;
          tmo_d   = '0;
        end
      end
      FLUSH: begin
        icache_invalidate_o = op_q;
        icache_flush_o      = !op_q;
        if (icache_accept_i) begin
          state_d = REDIRECT;
        end else if (tmo_q == TmoLast) begin
          // Give up on the cache but still restart fetch so the core cannot hang.
          timeout_d = 1'b1;
          state_d   = REDIRECT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      REDIRECT: begin
        // The restart redirect owns the port; a concurrent exec redirect is dropped.
        branch_request_o = 1'b1;
        branch_pc_o      = pc_q;
        branch_priv_o    = priv_q;
        done_o           = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q != IDLE);
  assign timeout_o = timeout_q;

endmodule
